// File: rtl/hamming_tx.sv
// Hamming(7,4) serial transmitter: encodes a nibble and shifts the codeword out MSB (A[6]) first.
// Optional error injection is enabled by defining HAMMING_TX_ERRINJ_EN (adds inj_en / inj_pos).
module hamming_tx (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_data,
`ifdef HAMMING_TX_ERRINJ_EN
   input  logic       inj_en,
   input  logic [2:0] inj_pos,
`endif
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       tx_bit,
   output logic       tx_sof,
   output logic       tx_eof,
   output logic [7:0] frame_cnt
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t     state, state_nx;
   logic [6:0] shreg, shreg_nx;
   logic [2:0] cnt, cnt_nx;
   logic [7:0] frame_cnt_nx;
   logic [6:0] code, load_word;
   logic       last, xfer, hs;

   // Bit order {A6..A0} = {D3, D2, D1, P3, D0, P1, P0}
   function automatic logic [6:0] encode(input logic [3:0] d);
      return {d[3], d[2], d[1], d[3] ^ d[2] ^ d[1], d[0],
              d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0]};
   endfunction

   always_comb begin
      code      = encode(in_data);
      load_word = code;
`ifdef HAMMING_TX_ERRINJ_EN
      if (inj_en && (inj_pos != 3'd7))
         load_word = code ^ (7'b000_0001 << inj_pos);
`endif
   end

   always_comb begin
      tx_valid = (state == SEND);
      last     = tx_valid && (cnt == 3'd6);
      xfer     = tx_valid && tx_ready;
      in_ready = (state == IDLE) || (last && tx_ready);
      hs       = in_valid && in_ready;
      tx_bit   = tx_valid && shreg[6];
      tx_sof   = tx_valid && (cnt == 3'd0);
      tx_eof   = last;
   end

   // A new word loaded on the final-bit edge overrides the return to IDLE.
   always_comb begin
      state_nx     = state;
      shreg_nx     = shreg;
      cnt_nx       = cnt;
      frame_cnt_nx = frame_cnt;
      if (xfer) begin
         shreg_nx = {shreg[5:0], 1'b0};
         cnt_nx   = cnt + 3'd1;
         if (last) begin
            frame_cnt_nx = frame_cnt + 8'd1;
            state_nx     = IDLE;
            cnt_nx       = '0;
         end
      end
      if (hs) begin
         shreg_nx = load_word;
         cnt_nx   = '0;
         state_nx = SEND;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shreg     <= '0;
         cnt       <= '0;
         frame_cnt <= '0;
      end else begin
         state     <= state_nx;
         shreg     <= shreg_nx;
         cnt       <= cnt_nx;
         frame_cnt <= frame_cnt_nx;
      end
   end

endmodule

// File: tb/tb_hamming_tx.sv
// Self-checking bench for hamming_tx: behavioural word/bit model plus directed scenarios.
module tb_hamming_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_bit;
   logic       tx_sof;
   logic       tx_eof;
   logic [7:0] frame_cnt;
`ifdef HAMMING_TX_ERRINJ_EN
   logic       inj_en;
   logic [2:0] inj_pos;
`endif

   hamming_tx dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
`ifdef HAMMING_TX_ERRINJ_EN
      .inj_en    (inj_en),
      .inj_pos   (inj_pos),
`endif
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_bit    (tx_bit),
      .tx_sof    (tx_sof),
      .tx_eof    (tx_eof),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Classic Hamming positions 1..7: parity at powers of two, data elsewhere; A[i] = pos i+1.
   function automatic logic [6:0] enc(input logic [3:0] d);
      logic [7:0] h;
      int unsigned k;
      h = '0;
      k = 0;
      for (int unsigned pos = 1; pos <= 7; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            h[pos] = d[k];
            k++;
         end
      end
      for (int unsigned p = 1; p <= 4; p = p * 2) begin
         logic par;
         par = 1'b0;
         for (int unsigned pos = 1; pos <= 7; pos++)
            if (((pos & p) != 0) && (pos != p)) par = par ^ h[pos];
         h[p] = par;
      end
      return h[7:1];
   endfunction

   // Reference model: one word in flight, indexed by the bit being presented.
   logic       m_busy;
   int         m_idx;
   logic [6:0] m_word;
   int         m_frames;
   logic [6:0] m_load;
   logic       m_rdy, m_hs;

   always_comb begin
      m_load = enc(in_data);
`ifdef HAMMING_TX_ERRINJ_EN
      if (inj_en && inj_pos != 3'd7) m_load[inj_pos] = ~m_load[inj_pos];
`endif
      m_rdy = !m_busy || (m_idx == 6 && tx_ready);
      m_hs  = in_valid && m_rdy;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy   <= 1'b0;
         m_idx    <= 0;
         m_word   <= '0;
         m_frames <= 0;
      end else begin
         if (m_busy && tx_ready) begin
            if (m_idx == 6) begin
               m_frames <= m_frames + 1;
               m_busy   <= 1'b0;
            end else m_idx <= m_idx + 1;
         end
         if (m_hs) begin
            m_word <= m_load;
            m_idx  <= 0;
            m_busy <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("tx_valid", 32'(tx_valid), 32'(m_busy));
         chk("tx_bit", 32'(tx_bit), 32'(m_busy ? m_word[6 - m_idx] : 1'b0));
         chk("tx_sof", 32'(tx_sof), 32'(m_busy && m_idx == 0));
         chk("tx_eof", 32'(tx_eof), 32'(m_busy && m_idx == 6));
         chk("in_ready", 32'(in_ready), 32'(m_rdy));
         chk("frame_cnt", 32'(frame_cnt), 32'(m_frames % 256));
      end
   end

   // Capture completed serial words and the length of each run of tx_valid.
   logic [6:0] cap;
   logic [6:0] words[$];
   int         run;
   int         last_run = 0;

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap <= '0;
         run <= 0;
      end else begin
         if (tx_valid && tx_ready) begin
            cap <= {cap[5:0], tx_bit};
            if (tx_eof) words.push_back({cap[5:0], tx_bit});
         end
         if (tx_valid) run <= run + 1;
         else begin
            if (run != 0) last_run <= run;
            run <= 0;
         end
      end
   end

   function automatic logic [6:0] word_at(input int i);
      if (i >= 0 && i < words.size()) return words[i];
      return 'x;
   endfunction

   logic [3:0] din_q[$];

   task automatic push_all(input int budget);
      int  n;
      logic hs;
      n = 0;
      @(posedge clk); #1;
      while (din_q.size() > 0 && n < budget) begin
         in_valid = 1'b1;
         in_data  = din_q[0];
         @(negedge clk);
         hs = in_ready;
         @(posedge clk); #1;
         if (hs) void'(din_q.pop_front());
         n++;
      end
      in_valid = 1'b0;
      chk("push_timeout", 32'(din_q.size()), 32'(0));
      din_q.delete();
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tx_valid && n < budget);
      chk("idle_timeout", 32'(tx_valid), 32'(0));
      #1;
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      #4;
      rst_n = 1'b1;
   endtask

   int base;

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      tx_ready = 1'b0;
`ifdef HAMMING_TX_ERRINJ_EN
      inj_en   = 1'b0;
      inj_pos  = '0;
`endif
      chk("enc_1011", 32'(enc(4'b1011)), 32'(7'b1010101));
      chk("enc_0000", 32'(enc(4'b0000)), 32'(7'b0000000));
      chk("enc_1111", 32'(enc(4'b1111)), 32'(7'b1111111));
      chk("enc_0001", 32'(enc(4'b0001)), 32'(7'b0000111));

      #12;
      chk("rst_tx_valid", 32'(tx_valid), 32'(0));
      chk("rst_tx_bit", 32'(tx_bit), 32'(0));
      chk("rst_sof_eof", 32'({tx_sof, tx_eof}), 32'(0));
      chk("rst_in_ready", 32'(in_ready), 32'(1));
      chk("rst_frame_cnt", 32'(frame_cnt), 32'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Single word, downstream always ready
      tx_ready = 1'b1;
      base = words.size();
      din_q = '{4'b1011};
      push_all(10);
      wait_idle(20);
      chk("w1011_word", 32'(word_at(base)), 32'(7'b1010101));
      chk("w1011_len", 32'(last_run), 32'(7));
      chk("w1011_frames", 32'(frame_cnt), 32'(1));

      // Back-to-back words with no bubble
      base = words.size();
      din_q = '{4'b0000, 4'b1111, 4'b0001};
      push_all(40);
      wait_idle(40);
      chk("b2b_w0", 32'(word_at(base)), 32'(7'b0000000));
      chk("b2b_w1", 32'(word_at(base + 1)), 32'(7'b1111111));
      chk("b2b_w2", 32'(word_at(base + 2)), 32'(7'b0000111));
      chk("b2b_run", 32'(last_run), 32'(21));

      // Downstream stall at cnt==2
      base = words.size();
      din_q = '{4'b1011};
      push_all(10);
      repeat (2) @(posedge clk);
      #1 tx_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("stall_bit", 32'(tx_bit), 32'(1));
         chk("stall_in_ready", 32'(in_ready), 32'(0));
      end
      @(posedge clk); #1;
      tx_ready = 1'b1;
      wait_idle(20);
      chk("stall_word", 32'(word_at(base)), 32'(7'b1010101));

      // Reset in the middle of a frame
      din_q = '{4'b1011};
      push_all(10);
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_tx_valid", 32'(tx_valid), 32'(0));
      chk("abort_frame_cnt", 32'(frame_cnt), 32'(0));
      chk("abort_in_ready", 32'(in_ready), 32'(1));
      #3 rst_n = 1'b1;
      base = words.size();
      din_q = '{4'b0001};
      push_all(10);
      wait_idle(20);
      chk("post_abort_word", 32'(word_at(base)), 32'(7'b0000111));
      chk("post_abort_frames", 32'(frame_cnt), 32'(1));
      chk("post_abort_nwords", 32'(words.size() - base), 32'(1));

      // 256 frames wrap the counter
      pulse_reset();
      base = words.size();
      for (int i = 0; i < 256; i++) din_q.push_back(4'($urandom));
      push_all(3000);
      wait_idle(20);
      chk("wrap_frame_cnt", 32'(frame_cnt), 32'(0));
      chk("wrap_nwords", 32'(words.size() - base), 32'(256));

`ifdef HAMMING_TX_ERRINJ_EN
      base = words.size();
      inj_en = 1'b1;
      inj_pos = 3'd6;
      din_q = '{4'b1011};
      push_all(10);
      wait_idle(20);
      inj_pos = 3'd7;
      din_q = '{4'b1011};
      push_all(10);
      wait_idle(20);
      inj_en = 1'b0;
      chk("inj_pos6", 32'(word_at(base)), 32'(7'b0010101));
      chk("inj_pos7", 32'(word_at(base + 1)), 32'(7'b1010101));
`endif

      // Randomized traffic with backpressure and a mid-run reset
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         in_valid = 1'($urandom);
         in_data  = 4'($urandom);
         tx_ready = (($urandom % 4) != 0);
`ifdef HAMMING_TX_ERRINJ_EN
         inj_en  = 1'($urandom);
         inj_pos = 3'($urandom);
`endif
         if (i == 2000) begin
            rst_n = 1'b0;
            #4 rst_n = 1'b1;
         end
      end
      in_valid = 1'b0;
      tx_ready = 1'b1;
      wait_idle(20);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
